// File: rtl/systola_pkg.sv
// Shared constants and types for the Systola PLM/DMA datapath.
package systola_pkg;

  localparam int PLM_AW = 11;

  // PLM region bases: operand A, operand B, results
  localparam logic [PLM_AW-1:0] BASE_A   = 11'd0;
  localparam logic [PLM_AW-1:0] BASE_B   = 11'd512;
  localparam logic [PLM_AW-1:0] BASE_OUT = 11'd1024;

  localparam logic [2:0] SIZE_32 = 3'b010;
  localparam logic [2:0] SIZE_64 = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FETCH,
    SEND,
    DONE
  } store_state_e;

  function automatic logic [2:0] dma_size(input int width);
    return (width == 64) ? SIZE_64 : SIZE_32;
  endfunction

endpackage

// File: rtl/systola_beat_packer.sv
// Byte-lane capture register: fills lanes LSB-first, flags full after the last lane.
module systola_beat_packer #(
  parameter int DMA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             cap,
  input  logic [7:0]       din,
  output logic [DMA_W-1:0] data,
  output logic             full,
  output logic             last
);
  localparam int BYTES = DMA_W / 8;
  localparam int LW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [LW-1:0] lane_reg;
  logic          full_reg;
  logic [7:0]    lane_q [BYTES];

  assign last = cap && (lane_reg == LW'(BYTES - 1));
  assign full = full_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_reg <= '0;
      full_reg <= 1'b0;
    end else if (clear) begin
      lane_reg <= '0;
      full_reg <= 1'b0;
    end else if (cap) begin
      lane_reg <= last ? '0 : lane_reg + 1'b1;
      if (last) full_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          lane_q[gi] <= '0;
        else if (cap && lane_reg == LW'(gi))
          lane_q[gi] <= din;
      end
      assign data[8*gi +: 8] = lane_q[gi];
    end
  endgenerate

endmodule

// File: rtl/systola_plm_store.sv
// Store-side DMA engine: PLM bytes -> packed DMA beats after one write request.
// SYSTOLA_STORE_PREFETCH_EN adds a second beat buffer so fetch overlaps send.
module systola_plm_store #(
  parameter int DMA_W  = 32,
  parameter int PLM_AW = systola_pkg::PLM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PLM_AW-1:0] cfg_plm_base,
  input  logic [31:0]       cfg_len,
  input  logic [31:0]       cfg_dram_index,
  output logic              busy,
  output logic              done,
  output logic [PLM_AW-1:0] plm_a,
  output logic              plm_ce,
  input  logic [7:0]        plm_q,
  output logic              dma_write_ctrl_valid,
  input  logic              dma_write_ctrl_ready,
  output logic [31:0]       dma_write_ctrl_data_index,
  output logic [31:0]       dma_write_ctrl_data_length,
  output logic [2:0]        dma_write_ctrl_data_size,
  output logic              dma_write_chnl_valid,
  input  logic              dma_write_chnl_ready,
  output logic [DMA_W-1:0]  dma_write_chnl_data
);
  import systola_pkg::*;

  localparam int BYTES = DMA_W / 8;
  localparam int LW    = (BYTES > 1) ? $clog2(BYTES) : 1;
`ifdef SYSTOLA_STORE_PREFETCH_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  store_state_e state_reg, state_next;

  logic [PLM_AW-1:0] addr_reg;
  logic [31:0]       len_reg, index_reg, fetch_left_reg, send_left_reg;
  logic [LW-1:0]     rd_cnt_reg;
  logic              fsel_reg, ssel_reg, cap_reg, cap_sel_reg;
  logic [1:0]        claim_reg;
  logic [1:0]        full, last;
  logic [DMA_W-1:0]  buf_data [2];
  logic              streaming, issue, beat_issued, hs;

  assign streaming   = (state_reg == FETCH) || (state_reg == SEND);
  // A buffer is claimed from its first read until its beat is accepted.
  assign issue       = streaming && (fetch_left_reg != 0) &&
                       ((rd_cnt_reg != 0) || !claim_reg[fsel_reg]);
  assign beat_issued = issue && (rd_cnt_reg == LW'(BYTES - 1));
  assign hs          = dma_write_chnl_valid && dma_write_chnl_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NBUF; gi++) begin : g_buf
      systola_beat_packer #(.DMA_W(DMA_W)) u_packer (
        .clk   (clk),
        .rst   (rst),
        .clear (hs && ssel_reg == 1'(gi)),
        .cap   (cap_reg && cap_sel_reg == 1'(gi)),
        .din   (plm_q),
        .data  (buf_data[gi]),
        .full  (full[gi]),
        .last  (last[gi])
      );
    end
    if (NBUF == 1) begin : g_single
      assign full[1]     = 1'b0;
      assign last[1]     = 1'b0;
      assign buf_data[1] = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      len_reg        <= '0;
      index_reg      <= '0;
      fetch_left_reg <= '0;
      send_left_reg  <= '0;
      rd_cnt_reg     <= '0;
      fsel_reg       <= 1'b0;
      ssel_reg       <= 1'b0;
      cap_reg        <= 1'b0;
      cap_sel_reg    <= 1'b0;
      claim_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      cap_reg     <= issue;
      cap_sel_reg <= fsel_reg;
      if (state_reg == IDLE && start && cfg_len != 0) begin
        addr_reg       <= cfg_plm_base;
        len_reg        <= cfg_len;
        index_reg      <= cfg_dram_index;
        fetch_left_reg <= cfg_len;
        send_left_reg  <= cfg_len;
        rd_cnt_reg     <= '0;
        fsel_reg       <= 1'b0;
        ssel_reg       <= 1'b0;
      end
      if (issue) begin
        addr_reg   <= addr_reg + 1'b1;
        rd_cnt_reg <= beat_issued ? '0 : rd_cnt_reg + 1'b1;
        if (beat_issued) begin
          fetch_left_reg <= fetch_left_reg - 1;
          fsel_reg       <= (NBUF == 2) ? ~fsel_reg : 1'b0;
        end
      end
      if (hs) begin
        send_left_reg <= send_left_reg - 1;
        ssel_reg      <= (NBUF == 2) ? ~ssel_reg : 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (hs && ssel_reg == 1'(i))
          claim_reg[i] <= 1'b0;
        if (issue && rd_cnt_reg == 0 && fsel_reg == 1'(i))
          claim_reg[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = (cfg_len != 0) ? REQ : DONE;
      REQ:   if (dma_write_ctrl_ready) state_next = FETCH;
      FETCH, SEND: begin
        if (hs)
          state_next = (send_left_reg == 1) ? DONE : FETCH;
        else if (full[ssel_reg] || last[ssel_reg])
          state_next = SEND;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy                       = (state_reg == REQ) || streaming;
  assign done                       = (state_reg == DONE);
  assign plm_a                      = addr_reg;
  assign plm_ce                     = issue;
  assign dma_write_ctrl_valid       = (state_reg == REQ);
  assign dma_write_ctrl_data_index  = index_reg;
  assign dma_write_ctrl_data_length = len_reg;
  assign dma_write_ctrl_data_size   = dma_size(DMA_W);
  assign dma_write_chnl_valid       = streaming && full[ssel_reg];
  assign dma_write_chnl_data        = buf_data[ssel_reg];

endmodule

// File: tb/tb_systola_plm_store.sv
// Directed bench for systola_plm_store with a 2048x8 PLM model and handshake monitor.
module tb_systola_plm_store;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [10:0] cfg_plm_base = '0;
  logic [31:0] cfg_len = '0;
  logic [31:0] cfg_dram_index = '0;
  logic        busy, done, plm_ce;
  logic [10:0] plm_a;
  logic [7:0]  plm_q = '0;
  logic        ctrl_valid, ctrl_ready = 1'b0;
  logic [31:0] ctrl_index, ctrl_length;
  logic [2:0]  ctrl_size;
  logic        chnl_valid, chnl_ready = 1'b0;
  logic [31:0] chnl_data;

  systola_plm_store #(.DMA_W(32), .PLM_AW(11)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .start                      (start),
    .cfg_plm_base               (cfg_plm_base),
    .cfg_len                    (cfg_len),
    .cfg_dram_index             (cfg_dram_index),
    .busy                       (busy),
    .done                       (done),
    .plm_a                      (plm_a),
    .plm_ce                     (plm_ce),
    .plm_q                      (plm_q),
    .dma_write_ctrl_valid       (ctrl_valid),
    .dma_write_ctrl_ready       (ctrl_ready),
    .dma_write_ctrl_data_index  (ctrl_index),
    .dma_write_ctrl_data_length (ctrl_length),
    .dma_write_ctrl_data_size   (ctrl_size),
    .dma_write_chnl_valid       (chnl_valid),
    .dma_write_chnl_ready       (chnl_ready),
    .dma_write_chnl_data        (chnl_data)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [2048];
  always @(posedge clk) if (plm_ce) plm_q <= mem[plm_a];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int ce_cnt, ctrl_cnt, done_cnt, first_ce, first_ctrl, first_valid, start_cyc;
  logic [31:0] beats[$];
  int rd_addr[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the DUT on the falling edge, away from the active edge.
  always @(negedge clk) if (rst) begin
    if (plm_ce) begin
      ce_cnt++;
      rd_addr.push_back(int'(plm_a));
      if (first_ce < 0) first_ce = cyc;
    end
    if (ctrl_valid) begin
      ctrl_cnt++;
      if (first_ctrl < 0) first_ctrl = cyc;
    end
    if (chnl_valid && first_valid < 0) first_valid = cyc;
    if (chnl_valid && chnl_ready) begin
      beats.push_back(chnl_data);
      $display("beat %0d accepted at cycle %0d data=0x%08h", beats.size() - 1, cyc, chnl_data);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ce_cnt = 0; ctrl_cnt = 0; done_cnt = 0;
    first_ce = -1; first_ctrl = -1; first_valid = -1;
    beats.delete();
    rd_addr.delete();
  endtask

  task automatic start_xfer(input logic [10:0] base, input logic [31:0] len, input logic [31:0] idx);
    start = 1'b1; cfg_plm_base = base; cfg_len = len; cfg_dram_index = idx;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    tick();
    check(tag, done_cnt, 1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget && !chnl_valid; i++) tick();
    check(tag, chnl_valid, 1);
  endtask

  function automatic logic [31:0] beat_at(input int i);
    return (beats.size() > i) ? beats[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int addr_at(input int i);
    return (rd_addr.size() > i) ? rd_addr[i] : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, bad;
    logic [31:0] d0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 8; i++) mem[1024 + i] = 8'(8'h11 * (i + 1));
    mem[2046] = 8'hA1; mem[2047] = 8'hB2; mem[0] = 8'hC3; mem[1] = 8'hD4;
    clear_logs();

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ctrl_valid", ctrl_valid, 0);
    check("rst_chnl_valid", chnl_valid, 0);
    check("rst_plm_ce", plm_ce, 0);
    check("rst_plm_a", plm_a, 0);
    check("rst_size", ctrl_size, 3'b010);
    check("rst_index", ctrl_index, 0);
    check("rst_chnl_data", chnl_data, 0);
    rst = 1'b1;
    tick();

    // Basic transfer
    ctrl_ready = 1'b1; chnl_ready = 1'b1;
    clear_logs();
    start_xfer(11'd1024, 32'd2, 32'h40);
    check("basic_ctrl_valid", ctrl_valid, 1);
    check("basic_index", ctrl_index, 32'h40);
    check("basic_length", ctrl_length, 2);
    check("basic_size", ctrl_size, 3'b010);
    check("basic_busy", busy, 1);
    wait_done("basic_done", 60);
    check("basic_ctrl_cycle", first_ctrl, start_cyc);
    check("basic_fetch_cycle", first_ce, start_cyc + 1);
    check("basic_valid_cycle", first_valid, start_cyc + 6);
    check("basic_nbeats", beats.size(), 2);
    check("basic_beat0", beat_at(0), 32'h44332211);
    check("basic_beat1", beat_at(1), 32'h88776655);
    check("basic_reads", ce_cnt, 8);
    check("basic_ctrl_count", ctrl_cnt, 1);
    check("basic_addr_first", addr_at(0), 1024);
    check("basic_addr_last", addr_at(7), 1031);

    // Backpressure on beat 0
    chnl_ready = 1'b0;
    clear_logs();
    start_xfer(11'd1024, 32'd2, 32'h40);
    wait_valid("bp_valid_seen", 40);
    d0 = chnl_data;
    bad = 0;
    repeat (5) begin
      tick();
      if (!chnl_valid || chnl_data !== d0) bad++;
    end
    check("bp_stable", bad, 0);
    check("bp_held_data", d0, 32'h44332211);
    chnl_ready = 1'b1;
    wait_done("bp_done", 60);
    check("bp_nbeats", beats.size(), 2);
    check("bp_beat1", beat_at(1), 32'h88776655);
    check("bp_reads", ce_cnt, 8);

    // Request stall
    ctrl_ready = 1'b0;
    clear_logs();
    start_xfer(11'd1024, 32'd1, 32'h40);
    repeat (10) tick();
    check("stall_no_reads", ce_cnt, 0);
    check("stall_valid_held", ctrl_valid, 1);
    ctrl_ready = 1'b1;
    m = cyc;
    wait_done("stall_done", 60);
    check("stall_fetch_cycle", first_ce, m + 1);
    check("stall_beat0", beat_at(0), 32'h44332211);

    // Zero length
    clear_logs();
    start_xfer(11'd1024, 32'd0, 32'h77);
    check("zero_done_pulse", done, 1);
    check("zero_busy", busy, 0);
    repeat (3) tick();
    check("zero_done_count", done_cnt, 1);
    check("zero_no_ctrl", ctrl_cnt, 0);
    check("zero_no_reads", ce_cnt, 0);

    // Wrap-around
    clear_logs();
    start_xfer(11'd2046, 32'd1, 32'h80);
    wait_done("wrap_done", 60);
    check("wrap_nreads", rd_addr.size(), 4);
    check("wrap_a0", addr_at(0), 2046);
    check("wrap_a1", addr_at(1), 2047);
    check("wrap_a2", addr_at(2), 0);
    check("wrap_a3", addr_at(3), 1);
    check("wrap_beat", beat_at(0), 32'hD4C3B2A1);

    // Busy-start ignored, then reset mid-SEND
    ctrl_ready = 1'b0; chnl_ready = 1'b0;
    clear_logs();
    start_xfer(11'd1024, 32'd2, 32'h40);
    tick();
    start_xfer(11'd0, 32'd5, 32'h99);
    check("busy_start_index", ctrl_index, 32'h40);
    check("busy_start_length", ctrl_length, 2);
    ctrl_ready = 1'b1;
    wait_valid("rst_valid_seen", 40);
    tick();
    rst = 1'b0;
    #1;
    check("abort_chnl_valid", chnl_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_plm_ce", plm_ce, 0);
    repeat (3) tick();
    clear_logs();
    rst = 1'b1; chnl_ready = 1'b1;
    repeat (6) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
